// File: rtl/aes_inv_cipher_iter_if.sv
// rtl/aes_inv_cipher_iter_if.sv - handshake, block and round-key port bundle for aes_inv_cipher_iter
interface aes_inv_cipher_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;
    logic         busy;

    // Datapath controller plus key-schedule store side
    modport master (
        output in_valid, ciphertext, rk_data, out_ready,
        input  in_ready, rk_addr, out_valid, plaintext, busy
    );

    // Inverse cipher side
    modport slave (
        input  in_valid, ciphertext, rk_data, out_ready,
        output in_ready, rk_addr, out_valid, plaintext, busy
    );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES-128/192/256 inverse cipher, one round per clock; AES_INV_ABORT_EN adds the abort input
module aes_inv_cipher_iter #(
    parameter int KEY_BITS = 256
) (
    input  logic clk,
    input  logic rst,
`ifdef AES_INV_ABORT_EN
    input  logic abort,
`endif
    aes_inv_cipher_iter_if.slave bus
);
    localparam int         NR      = (KEY_BITS == 128) ? 10 : (KEY_BITS == 192) ? 12 : 14;
    localparam logic [3:0] NR_ADDR = 4'(NR);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_inv_cipher_iter: KEY_BITS must be 128, 192 or 256");
    end

    // Inverse S-box, element 0 is the leftmost byte
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t       state, state_nx;
    logic [127:0] st, st_nx;
    logic [3:0]   rc, rc_nx;
    logic [127:0] pt_q, pt_nx;
    logic         accept_ok;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit GF(2^8) constant (0x09, 0x0b, 0x0d, 0x0e)
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    // InvSubBytes(InvShiftRows(s)); byte 4*c+r sits in row r, column c
    function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127 - 8 * (4 * c + w) -: 8] = INV_SBOX[s[127 - 8 * (4 * ((c - w + 4) % 4) + w) -: 8]];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            r[127 - 32 * c -: 32] = {
                gf_mul(a0, 4'd14) ^ gf_mul(a1, 4'd11) ^ gf_mul(a2, 4'd13) ^ gf_mul(a3, 4'd9),
                gf_mul(a0, 4'd9)  ^ gf_mul(a1, 4'd14) ^ gf_mul(a2, 4'd11) ^ gf_mul(a3, 4'd13),
                gf_mul(a0, 4'd13) ^ gf_mul(a1, 4'd9)  ^ gf_mul(a2, 4'd14) ^ gf_mul(a3, 4'd11),
                gf_mul(a0, 4'd11) ^ gf_mul(a1, 4'd13) ^ gf_mul(a2, 4'd9)  ^ gf_mul(a3, 4'd14)
            };
        end
        return r;
    endfunction

    // Next state, datapath next values and handshake outputs; rk_addr depends only on state and rc
    always_comb begin
        state_nx     = state;
        st_nx        = st;
        rc_nx        = rc;
        pt_nx        = pt_q;
        accept_ok    = !rst;
`ifdef AES_INV_ABORT_EN
        accept_ok    = !rst && !abort;
`endif
        bus.in_ready = 1'b0;
        bus.rk_addr  = NR_ADDR;
        case (state)
            IDLE: begin
                bus.in_ready = accept_ok;
                bus.rk_addr  = NR_ADDR;
                if (bus.in_valid && accept_ok) begin
                    st_nx    = bus.ciphertext ^ bus.rk_data;
                    rc_nx    = NR_ADDR - 4'd1;
                    state_nx = ROUND;
                end
            end
            ROUND: begin
                bus.rk_addr = rc;
                st_nx       = inv_mix_columns(inv_sub_shift(st) ^ bus.rk_data);
                if (rc > 4'd1) begin
                    rc_nx = rc - 4'd1;
                end else begin
                    state_nx = FINAL;
                end
            end
            FINAL: begin
                bus.rk_addr = 4'd0;
                pt_nx       = inv_sub_shift(st) ^ bus.rk_data;
                state_nx    = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
`ifdef AES_INV_ABORT_EN
        if (abort && state != IDLE) begin
            state_nx = IDLE;
            pt_nx    = pt_q;
        end
`endif
    end

    // State and datapath registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            st    <= '0;
            rc    <= '0;
            pt_q  <= '0;
        end else begin
            state <= state_nx;
            st    <= st_nx;
            rc    <= rc_nx;
            pt_q  <= pt_nx;
        end
    end

    assign bus.plaintext = pt_q;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb/tb_aes_inv_cipher_iter.sv - FIPS-197 directed and randomized checks of aes_inv_cipher_iter at 128/192/256-bit keys
module tb_aes_inv_cipher_iter;
    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192    = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256    = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst;
    logic         in_valid  [3];
    logic [127:0] ct_in     [3];
    logic         out_ready [3];
    logic         in_ready  [3];
    logic [3:0]   rk_addr   [3];
    logic         out_valid [3];
    logic [127:0] pt_out    [3];
    logic         busy      [3];
`ifdef AES_INV_ABORT_EN
    logic         abort_in  [3];
`endif
    logic [127:0] rk        [3][15];
    logic [7:0]   sbox      [256];

    int checks   = 0;
    int failures = 0;

    // Instance g runs KEY_BITS = 128 + 64*g, with its own round-key store
    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_inv_cipher_iter_if bus ();
        assign bus.in_valid   = in_valid[g];
        assign bus.ciphertext = ct_in[g];
        assign bus.out_ready  = out_ready[g];
        assign bus.rk_data    = (bus.rk_addr < 4'd15) ? rk[g][bus.rk_addr] : '0;
        assign in_ready[g]    = bus.in_ready;
        assign rk_addr[g]     = bus.rk_addr;
        assign out_valid[g]   = bus.out_valid;
        assign pt_out[g]      = bus.plaintext;
        assign busy[g]        = bus.busy;

        aes_inv_cipher_iter #(.KEY_BITS(128 + 64 * g)) u_dut (
            .clk   (clk),
            .rst   (rst),
`ifdef AES_INV_ABORT_EN
            .abort (abort_in[g]),
`endif
            .bus   (bus)
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Forward S-box from the field inverse followed by the affine map
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Key schedule for instance idx; the key occupies the top KEY_BITS of key
    task automatic load_keys(input int idx, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nk, nr;
        nk   = 4 + 2 * idx;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r < 15; r++) begin
            rk[idx][r] = (r <= nr) ? {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]} : '0;
        end
    endtask

    // Forward cipher; the bench checks decryption by round-tripping through it
    function automatic logic [127:0] encrypt(input int idx, input logic [127:0] p);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] k, res;
        int nr;
        nr = 10 + 2 * idx;
        k  = rk[idx][0];
        for (int i = 0; i < 16; i++) s[i] = p[127 - 8 * i -: 8] ^ k[127 - 8 * i -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++) begin
                for (int w = 0; w < 4; w++) s[4 * c + w] = t[4 * ((c + w) % 4) + w];
            end
            if (rnd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    logic [7:0] a0, a1, a2, a3;
                    a0 = s[4 * c];
                    a1 = s[4 * c + 1];
                    a2 = s[4 * c + 2];
                    a3 = s[4 * c + 3];
                    s[4 * c]     = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
                    s[4 * c + 1] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
                    s[4 * c + 2] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
                    s[4 * c + 3] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
                end
            end
            k = rk[idx][rnd];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127 - 8 * i -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    // Offer one block, follow it to DONE with optional backpressure, then release it
    task automatic run_block(input int idx, input logic [127:0] c, input logic [127:0] exp,
                             input bit hold, input int bp, output int acc_cyc, output int rel_cyc);
        int nr, n;
        nr = 10 + 2 * idx;
        chk($sformatf("in_ready_idle[%0d]", idx), in_ready[idx], 1);
        chk($sformatf("rk_addr_idle[%0d]", idx), rk_addr[idx], nr);
        in_valid[idx] = 1'b1;
        ct_in[idx]    = c;
        @(posedge clk); #1;
        acc_cyc = cyc;
        n = 1;
        if (!hold) in_valid[idx] = 1'b0;
        while (out_valid[idx] !== 1'b1 && n <= nr + 3) begin
            if (n <= nr) chk($sformatf("rk_addr_seq[%0d] n=%0d", idx, n), rk_addr[idx], nr - n);
            chk($sformatf("in_ready_busy[%0d] n=%0d", idx, n), in_ready[idx], 0);
            if (hold) ct_in[idx] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            n++;
        end
        in_valid[idx] = 1'b0;
        chk($sformatf("latency[%0d]", idx), n, nr + 1);
        chk($sformatf("plaintext[%0d]", idx), pt_out[idx], exp);
        for (int k = 0; k < bp; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_valid[%0d]", idx), out_valid[idx], 1);
            chk($sformatf("bp_plaintext[%0d]", idx), pt_out[idx], exp);
        end
        out_ready[idx] = 1'b1;
        @(posedge clk); #1;
        rel_cyc = cyc;
        out_ready[idx] = 1'b0;
        chk($sformatf("release_valid[%0d]", idx), out_valid[idx], 0);
        chk($sformatf("release_busy[%0d]", idx), busy[idx], 0);
    endtask

    initial begin
        int a1, r1, a2, r2, a3, r3;
        logic [127:0] p, c;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            ct_in[i]     = '0;
            out_ready[i] = 1'b0;
`ifdef AES_INV_ABORT_EN
            abort_in[i]  = 1'b0;
`endif
        end
        build_sbox();
        for (int i = 0; i < 3; i++) load_keys(i, FIPS_KEY);

        // Reset values, in_ready held low by rst
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_busy[%0d]", i), busy[i], 0);
            chk($sformatf("rst_out_valid[%0d]", i), out_valid[i], 0);
            chk($sformatf("rst_plaintext[%0d]", i), pt_out[i], 0);
            chk($sformatf("rst_in_ready[%0d]", i), in_ready[i], 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // FIPS-197 Appendix C vectors; 256-bit case keeps in_valid high and scrambles ciphertext
        run_block(0, CT128, FIPS_PT, 1'b0, 0, a1, r1);
        run_block(1, CT192, FIPS_PT, 1'b0, 0, a1, r1);
        run_block(2, CT256, FIPS_PT, 1'b1, 0, a1, r1);

        // Backpressure, then back-to-back acceptance and steady throughput
        run_block(2, CT256, FIPS_PT, 1'b0, 20, a1, r1);
        run_block(2, CT256, FIPS_PT, 1'b0, 0, a2, r2);
        chk("b2b_accept_gap", a2 - r1, 1);
        run_block(2, CT256, FIPS_PT, 1'b0, 0, a3, r3);
        chk("throughput_256", a3 - a2, 16);

        // Reset at rc = 7 discards the block; in_valid held high is ignored under rst
        in_valid[2] = 1'b1;
        ct_in[2]    = CT256;
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("rc7_rk_addr", rk_addr[2], 7);
        rst         = 1'b1;
        in_valid[2] = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready_low", in_ready[2], 0);
        chk("midrst_busy", busy[2], 0);
        @(posedge clk); #1;
        chk("rst_ignores_in_valid", busy[2], 0);
        rst         = 1'b0;
        in_valid[2] = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid[2], 0);
        chk("midrst_plaintext", pt_out[2], 0);
        chk("midrst_in_ready", in_ready[2], 1);
        run_block(2, CT256, FIPS_PT, 1'b0, 0, a1, r1);

`ifdef AES_INV_ABORT_EN
        // Abort at rc = 7 keeps the previous plaintext
        in_valid[2] = 1'b1;
        ct_in[2]    = CT256;
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        abort_in[2] = 1'b1;
        @(posedge clk); #1;
        abort_in[2] = 1'b0;
        #1;
        chk("abort_out_valid", out_valid[2], 0);
        chk("abort_busy", busy[2], 0);
        chk("abort_plaintext_kept", pt_out[2], FIPS_PT);
        chk("abort_in_ready", in_ready[2], 1);
        // Abort in IDLE blocks acceptance
        abort_in[2] = 1'b1;
        in_valid[2] = 1'b1;
        #1;
        chk("abort_idle_in_ready", in_ready[2], 0);
        @(posedge clk); #1;
        chk("abort_idle_no_accept", busy[2], 0);
        abort_in[2] = 1'b0;
        in_valid[2] = 1'b0;
        // rst beats abort
        in_valid[2] = 1'b1;
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        rst         = 1'b1;
        abort_in[2] = 1'b1;
        @(posedge clk); #1;
        rst         = 1'b0;
        abort_in[2] = 1'b0;
        #1;
        chk("rst_over_abort_plaintext", pt_out[2], 0);
        run_block(2, CT256, FIPS_PT, 1'b0, 0, a1, r1);
`endif

        // Random keys and plaintexts, round-tripped through the forward model
        for (int rep = 0; rep < 9; rep++) begin
            int idx;
            idx = rep % 3;
            load_keys(idx, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            p = {$urandom, $urandom, $urandom, $urandom};
            c = encrypt(idx, p);
            run_block(idx, c, p, 1'($urandom_range(0, 1)), $urandom_range(0, 3), a1, r1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
